msrv32_pc_gen: RTL and testbench

Parametrised, registered program-counter generator for the MSRV32 fetch stage. It supersedes the combinational PC mux. It holds the architectural PC in a register and selects the next PC from boot, EPC, trap, branch or sequential sources. It stalls on AHB wait states and buffers one redirect that arrives during a stall. It also detects misaligned branch targets and holds off fetch for a programmable number of cycles after reset.

---
 rtl/msrv32_pc_pkg.sv | 28 ++
 rtl/msrv32_pc_redirect_buf.sv | 44 ++++
 rtl/msrv32_pc_gen.sv | 127 ++++++++++++
 tb/tb_msrv32_pc_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pc_pkg.sv
// msrv32_pc_pkg: shared encodings and redirect priorities for the MSRV32 PC generator
package msrv32_pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'b00,
    PC_EPC  = 2'b01,
    PC_TRAP = 2'b10,
    PC_NEXT = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } pc_state_e;

  localparam logic [1:0] PRIO_BRANCH = 2'd0;
  localparam logic [1:0] PRIO_EPC    = 2'd1;
  localparam logic [1:0] PRIO_TRAP   = 2'd2;
  localparam logic [1:0] PRIO_BOOT   = 2'd3;

  function automatic logic [1:0] prio_of(input pc_src_e s);
    return s == PC_BOOT ? PRIO_BOOT :
           s == PC_TRAP ? PRIO_TRAP :
           s == PC_EPC  ? PRIO_EPC  : PRIO_BRANCH;
  endfunction

endpackage

// File: rtl/msrv32_pc_redirect_buf.sv
// msrv32_pc_redirect_buf: one-entry pending redirect, overwritten only by equal or higher priority
module msrv32_pc_redirect_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [1:0]      prio_i,
  output logic            accept_o,
  output logic            valid_o,
  output logic [XLEN-1:0] addr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      prio_q, prio_d;

  assign accept_o = !valid_q || prio_i >= prio_q;
  assign valid_o  = valid_q;
  assign addr_o   = addr_q;

  // clear wins over load; a load only lands when it outranks or ties the held entry
  always_comb begin
    valid_d = clear_i ? 1'b0 : (load_i && accept_o) ? 1'b1 : valid_q;
    addr_d  = (!clear_i && load_i && accept_o) ? addr_i : addr_q;
    prio_d  = (!clear_i && load_i && accept_o) ? prio_i : prio_q;
  end

  // buffer storage
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      prio_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: rtl/msrv32_pc_gen.sv
// msrv32_pc_gen: registered fetch PC with reset hold, AHB stall buffering and misalignment detect (MSRV32_RVC_EN: 16-bit alignment)
module msrv32_pc_gen
  import msrv32_pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int              RESET_HOLD   = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [1:0]      pc_src_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic            ahb_ready_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] iaddr_out,
  output logic            iaddr_valid_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic            misaligned_instr_out,
  output logic            redirect_pending_out
);

`ifdef MSRV32_RVC_EN
  localparam logic [XLEN-1:0] AMASK = ~XLEN'(1);
`else
  localparam logic [XLEN-1:0] AMASK = ~XLEN'(3);
`endif

  pc_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, cand, buf_addr;
  logic            mis_q, mis_d, taken, tgt_mis, mis_br, redirect;
  logic            buf_load, buf_clear, buf_accept, buf_valid;
  pc_src_e         src;

  assign src      = pc_src_e'(pc_src_in);
  assign pc_plus4 = pc_q + XLEN'(4);
  assign taken    = src == PC_NEXT && branch_taken_in;
`ifdef MSRV32_RVC_EN
  assign tgt_mis  = branch_target_in[0];
`else
  assign tgt_mis  = branch_target_in[1];
`endif
  assign mis_br   = taken && tgt_mis;
  assign redirect = (src != PC_NEXT || taken) && !mis_br;

  // candidate next PC from the selected source, with alignment forced on redirect targets
  always_comb begin
    cand = src == PC_BOOT ? BOOT_ADDRESS :
           src == PC_EPC  ? epc_in & AMASK :
           src == PC_TRAP ? trap_address_in & ~XLEN'(3) :
           taken          ? branch_target_in & AMASK : pc_plus4;
  end

  msrv32_pc_redirect_buf #(.XLEN(XLEN)) u_buf (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_i   (buf_load),
    .clear_i  (buf_clear),
    .addr_i   (cand),
    .prio_i   (prio_of(src)),
    .accept_o (buf_accept),
    .valid_o  (buf_valid),
    .addr_o   (buf_addr)
  );

  // fetch control: hold-off countdown, run, and stall with one buffered redirect
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    mis_d     = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state_q)
      ST_HOLD: begin
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q <= 4'd1 ? ST_RUN : ST_HOLD;
      end
      ST_RUN: begin
        mis_d = mis_br;
        if (ahb_ready_in) begin
          pc_d = mis_br ? pc_q : cand;
        end else if (redirect) begin
          buf_load = 1'b1;
          state_d  = ST_STALL;
        end
      end
      ST_STALL: begin
        mis_d = mis_br;
        if (ahb_ready_in) begin
          pc_d      = (redirect && buf_accept) ? cand : buf_addr;
          buf_clear = 1'b1;
          state_d   = ST_RUN;
        end else begin
          buf_load = redirect;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // architectural state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_HOLD;
      cnt_q   <= 4'(RESET_HOLD);
      pc_q    <= BOOT_ADDRESS;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_out               = pc_q;
  assign iaddr_out            = pc_q;
  assign iaddr_valid_out      = state_q != ST_HOLD;
  assign pc_plus_4_out        = pc_plus4;
  assign misaligned_instr_out = mis_q;
  assign redirect_pending_out = buf_valid;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// tb_msrv32_pc_gen: directed checks of reset hold, redirects, stall buffering, misalignment and wrap
module tb_msrv32_pc_gen;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  pc_src_in;
  logic [31:0] epc_in, trap_address_in, branch_target_in;
  logic        branch_taken_in, ahb_ready_in;
  logic [31:0] pc_out, iaddr_out, pc_plus_4_out;
  logic        iaddr_valid_out, misaligned_instr_out, redirect_pending_out;
  int          passed = 0;
  int          total = 0;
  logic [31:0] p;

  always #5 clk_in = ~clk_in;

  msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h0), .RESET_HOLD(2)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .pc_src_in            (pc_src_in),
    .epc_in               (epc_in),
    .trap_address_in      (trap_address_in),
    .branch_taken_in      (branch_taken_in),
    .branch_target_in     (branch_target_in),
    .ahb_ready_in         (ahb_ready_in),
    .pc_out               (pc_out),
    .iaddr_out            (iaddr_out),
    .iaddr_valid_out      (iaddr_valid_out),
    .pc_plus_4_out        (pc_plus_4_out),
    .misaligned_instr_out (misaligned_instr_out),
    .redirect_pending_out (redirect_pending_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic seq();
    pc_src_in = 2'b11;
    branch_taken_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0;
    seq();
    epc_in = '0;
    trap_address_in = '0;
    branch_target_in = '0;
    ahb_ready_in = 1'b1;
    #12;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_iaddr", iaddr_out, 32'h0);
    chk("rst_p4", pc_plus_4_out, 32'h4);
    chk("rst_valid", {31'b0, iaddr_valid_out}, 32'h0);
    chk("rst_mis", {31'b0, misaligned_instr_out}, 32'h0);
    chk("rst_pend", {31'b0, redirect_pending_out}, 32'h0);
    rst_in = 1'b1;
    tick();
    chk("hold1_valid", {31'b0, iaddr_valid_out}, 32'h0);
    chk("hold1_pc", pc_out, 32'h0);
    tick();
    chk("run_valid", {31'b0, iaddr_valid_out}, 32'h1);
    chk("run_pc0", pc_out, 32'h0);
    tick();
    chk("run_pc4", pc_out, 32'h4);
    tick();
    chk("run_pc8", pc_out, 32'h8);

    pc_src_in = 2'b10;
    trap_address_in = 32'h8765_4323;
    tick();
    chk("trap_pc", pc_out, 32'h8765_4320);
    chk("trap_p4", pc_plus_4_out, 32'h8765_4324);

    pc_src_in = 2'b11;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h0000_1002;
    tick();
`ifdef MSRV32_RVC_EN
    p = 32'h0000_1002;
    chk("br1002_mis", {31'b0, misaligned_instr_out}, 32'h0);
`else
    p = 32'h8765_4320;
    chk("br1002_mis", {31'b0, misaligned_instr_out}, 32'h1);
`endif
    chk("br1002_pc", pc_out, p);
    seq();
    tick();
    p = p + 32'h4;
    chk("br_after_mis", {31'b0, misaligned_instr_out}, 32'h0);
    chk("br_after_pc", pc_out, p);

    ahb_ready_in = 1'b0;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h0000_2000;
    tick();
    chk("stall_pend", {31'b0, redirect_pending_out}, 32'h1);
    chk("stall_pc", pc_out, p);
    pc_src_in = 2'b10;
    branch_taken_in = 1'b0;
    trap_address_in = 32'h0000_0100;
    tick();
    chk("stall2_pend", {31'b0, redirect_pending_out}, 32'h1);
    chk("stall2_pc", pc_out, p);
    seq();
    ahb_ready_in = 1'b1;
    tick();
    chk("apply_pc", pc_out, 32'h0000_0100);
    chk("apply_pend", {31'b0, redirect_pending_out}, 32'h0);

    ahb_ready_in = 1'b0;
    pc_src_in = 2'b10;
    trap_address_in = 32'h0000_0200;
    tick();
    pc_src_in = 2'b11;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h0000_3000;
    tick();
    chk("prio_hold_pc", pc_out, 32'h0000_0100);
    seq();
    ahb_ready_in = 1'b1;
    tick();
    chk("prio_pc", pc_out, 32'h0000_0200);

    ahb_ready_in = 1'b0;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h0000_1003;
    tick();
    chk("mis_stall_flag", {31'b0, misaligned_instr_out}, 32'h1);
    chk("mis_stall_pend", {31'b0, redirect_pending_out}, 32'h0);
    chk("mis_stall_pc", pc_out, 32'h0000_0200);
    seq();
    ahb_ready_in = 1'b1;
    tick();
    chk("mis_stall_clr", {31'b0, misaligned_instr_out}, 32'h0);
    chk("mis_stall_seq", pc_out, 32'h0000_0204);

    pc_src_in = 2'b01;
    epc_in = 32'h0000_0503;
    tick();
`ifdef MSRV32_RVC_EN
    chk("epc_pc", pc_out, 32'h0000_0502);
`else
    chk("epc_pc", pc_out, 32'h0000_0500);
`endif

    pc_src_in = 2'b10;
    trap_address_in = 32'hFFFF_FFFC;
    tick();
    chk("wrap_p4", pc_plus_4_out, 32'h0);
    seq();
    tick();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_p4b", pc_plus_4_out, 32'h4);

    ahb_ready_in = 1'b0;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h0000_2000;
    tick();
    chk("rst_stall_pend", {31'b0, redirect_pending_out}, 32'h1);
    rst_in = 1'b0;
    #1;
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_valid", {31'b0, iaddr_valid_out}, 32'h0);
    chk("arst_pend", {31'b0, redirect_pending_out}, 32'h0);
    seq();
    ahb_ready_in = 1'b1;
    #2;
    rst_in = 1'b1;
    tick();
    chk("rel_valid", {31'b0, iaddr_valid_out}, 32'h0);
    tick();
    chk("rel_valid2", {31'b0, iaddr_valid_out}, 32'h1);
    chk("rel_pc", pc_out, 32'h0);
    chk("rel_pend", {31'b0, redirect_pending_out}, 32'h0);
    tick();
    chk("rel_pc4", pc_out, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
